// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the
// clocks-per-bit helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    function automatic int clks_per_bit(
        input int clock_rate,
        input int baud_rate
    );
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input pin.
// Ports: clk, reset (sync, active-high), i_d (async in), o_q (synced out).
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-cycle valid / framing-error strobes.
// Ports: clk, reset (sync, active-high), rx_pin (async, idle high),
//        data[7:0], data_valid, framing_err, busy.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int CPB = clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLOCK_RATE/BAUD_RATE must be >= 4");
    end

    logic w_rxs;

    state_t                 r_state;
    logic [CW-1:0]          r_clk_cnt;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [7:0]             r_data;
    logic                   r_data_valid;
    logic                   r_framing_err;
    logic                   r_busy;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .i_d  (rx_pin),
        .o_q  (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_data        <= 8'h00;
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        if (!w_rxs) begin
                            r_state <= DATA;
                        end else begin
                            // Too short to be a start bit.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        // LSB arrives first, so shift in at the top.
                        r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        if (w_rxs) begin
                            // Back in IDLE at mid stop bit, so a start
                            // edge right after the stop bit is caught.
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_framing_err <= 1'b1;
                            r_state       <= BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a held-low
                    // line cannot retrigger a frame.
                    r_clk_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clk_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign data        = r_data;
    assign data_valid  = r_data_valid;
    assign framing_err = r_framing_err;
    assign busy        = r_busy;

endmodule
